// File: rtl/way_age_tracker_pkg.sv
// Shared definitions for the way age tracker: victim FSM encoding,
// way-index width derivation and the age saturation constant.
package way_age_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } victim_state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned age_sat(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int          DEF_AGE_W   = 4;
  localparam int unsigned DEF_AGE_SAT = age_sat(DEF_AGE_W);

endpackage

// File: rtl/way_age_counter.sv
// One way's saturating age counter and valid bit.
// Invalidate beats access; aging only applies to a valid way.
module way_age_counter
  import way_age_tracker_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         access_i,
  input  logic         invalidate_i,
  input  logic         age_en_i,
  output logic [W-1:0] age_o,
  output logic         valid_o
);

  localparam logic [W-1:0] SAT = W'(age_sat(W));

  logic [W-1:0] age_q, age_d;
  logic         valid_q, valid_d;

  always_comb begin
    age_d   = age_q;
    valid_d = valid_q;
    if (invalidate_i) begin
      age_d   = '0;
      valid_d = 1'b0;
    end else if (access_i) begin
      age_d   = '0;
      valid_d = 1'b1;
    end else if (age_en_i && valid_q && (age_q != SAT)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      age_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      valid_q <= valid_d;
    end
  end

  assign age_o   = age_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/way_age_tracker.sv
// Per-way age tracker with a snapshot-based, one-way-per-cycle victim search.
// Define WAY_AGE_TRACKER_INVALID_FIRST_EN to stop the search at the first invalid way.
module way_age_tracker
  import way_age_tracker_pkg::*;
#(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int NUM_WAY                  = 16,
  parameter int NUM_WAY_INDEX_WIDTH      = idx_width(NUM_WAY)
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic                                         access_valid_in,
  input  logic [NUM_WAY_INDEX_WIDTH-1:0]               access_way_in,
  input  logic                                         invalidate_valid_in,
  input  logic [NUM_WAY_INDEX_WIDTH-1:0]               invalidate_way_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
  output logic [NUM_WAY-1:0]                           condition_out,
  input  logic                                         victim_request_valid_in,
  output logic                                         victim_request_ready_out,
  output logic                                         victim_valid_out,
  output logic [NUM_WAY_INDEX_WIDTH-1:0]               victim_way_out,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          victim_age_out,
  input  logic                                         victim_ready_in
);

  localparam int W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int IW = NUM_WAY_INDEX_WIDTH;

  logic [NUM_WAY-1:0]        acc_hit, inv_hit, valid;
  logic [NUM_WAY-1:0][W-1:0] ages;

  for (genvar g = 0; g < NUM_WAY; g++) begin : g_way
    assign acc_hit[g] = access_valid_in     && (access_way_in     == IW'(g));
    assign inv_hit[g] = invalidate_valid_in && (invalidate_way_in == IW'(g));

    way_age_counter #(.W(W)) u_cnt (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .access_i     (acc_hit[g]),
      .invalidate_i (inv_hit[g]),
      .age_en_i     (access_valid_in),
      .age_o        (ages[g]),
      .valid_o      (valid[g])
    );
  end

  assign way_flatted_out = ages;
  assign condition_out   = valid;

  victim_state_e             state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [NUM_WAY-1:0][W-1:0] snap_age_q, snap_age_d;
  logic [NUM_WAY-1:0]        snap_vld_q, snap_vld_d;
  logic [IW-1:0]             best_way_q, best_way_d;
  logic [W-1:0]              best_age_q, best_age_d;
  logic                      ready_q, ready_d;
  logic                      vvalid_q, vvalid_d;
  logic [W-1:0]              cand_age;
  logic                      stop_early;
  logic                      last_idx;

  assign cand_age = snap_vld_q[idx_q] ? snap_age_q[idx_q] : '0;
  assign last_idx = (idx_q == IW'(NUM_WAY - 1));

`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
  assign stop_early = !snap_vld_q[idx_q];
`else
  assign stop_early = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_age_d = snap_age_q;
    snap_vld_d = snap_vld_q;
    best_way_d = best_way_q;
    best_age_d = best_age_q;
    ready_d    = ready_q;
    vvalid_d   = vvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (victim_request_valid_in && ready_q) begin
          snap_age_d = ages;
          snap_vld_d = valid;
          best_way_d = '0;
          best_age_d = '0;
          idx_d      = '0;
          ready_d    = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (stop_early) begin
          best_way_d = idx_q;
          best_age_d = '0;
          vvalid_d   = 1'b1;
          state_d    = ST_DONE;
        end else begin
          // strict compare keeps the lowest index on ties
          if (cand_age > best_age_q) begin
            best_way_d = idx_q;
            best_age_d = cand_age;
          end
          if (last_idx) begin
            vvalid_d = 1'b1;
            state_d  = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (victim_ready_in) begin
          vvalid_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        vvalid_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      snap_age_q <= '0;
      snap_vld_q <= '0;
      best_way_q <= '0;
      best_age_q <= '0;
      ready_q    <= 1'b1;
      vvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      snap_age_q <= snap_age_d;
      snap_vld_q <= snap_vld_d;
      best_way_q <= best_way_d;
      best_age_q <= best_age_d;
      ready_q    <= ready_d;
      vvalid_q   <= vvalid_d;
    end
  end

  assign victim_request_ready_out = ready_q;
  assign victim_valid_out         = vvalid_q;
  assign victim_way_out           = best_way_q;
  assign victim_age_out           = best_age_q;

endmodule

// File: tb/tb_way_age_tracker.sv
// Directed bench for way_age_tracker: table of access/invalidate vectors
// plus hand-written victim-search, saturation and mid-scan reset sequences.
module tb_way_age_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acc_v, inv_v, req_v, rdy_in;
  logic [3:0]  acc_w, inv_w;
  logic [63:0] flat;
  logic [15:0] cond;
  logic        req_rdy, vic_v;
  logic [3:0]  vic_way, vic_age;

  int checks = 0;
  int errors = 0;

  way_age_tracker #(
    .SINGLE_WAY_WIDTH_IN_BITS (4),
    .NUM_WAY                  (16)
  ) dut (
    .clk_in                   (clk),
    .reset_in                 (rst_n),
    .access_valid_in          (acc_v),
    .access_way_in            (acc_w),
    .invalidate_valid_in      (inv_v),
    .invalidate_way_in        (inv_w),
    .way_flatted_out          (flat),
    .condition_out            (cond),
    .victim_request_valid_in  (req_v),
    .victim_request_ready_out (req_rdy),
    .victim_valid_out         (vic_v),
    .victim_way_out           (vic_way),
    .victim_age_out           (vic_age),
    .victim_ready_in          (rdy_in)
  );

  always #5 clk = ~clk;

  function automatic int age_of(input int w);
    return int'(flat[w*4 +: 4]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic av, input int aw, input logic iv, input int iw);
    @(negedge clk);
    acc_v = av; acc_w = 4'(aw);
    inv_v = iv; inv_w = 4'(iw);
    @(posedge clk);
    #1;
    acc_v = 1'b0;
    inv_v = 1'b0;
  endtask

  // Issues a request and expects the result exp_n edges after the accepting edge.
  task automatic run_victim(input string tag, input int exp_n, input int exp_way,
                            input int exp_age, input int inv_during);
    int n;
    n = 0;
    @(negedge clk);
    req_v = 1'b1;
    @(posedge clk);
    #1;
    req_v = 1'b0;
    chk({tag, "_ready_low"}, req_rdy, 0);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 && inv_during >= 0) begin
        inv_v = 1'b1; inv_w = 4'(inv_during);
      end else begin
        inv_v = 1'b0;
      end
      if (vic_v) begin
        n = i;
        break;
      end
      chk({tag, "_scan_ready"}, req_rdy, 0);
    end
    inv_v = 1'b0;
    chk({tag, "_latency"}, (n == 0) ? 41 : n, exp_n);
    chk({tag, "_way"}, vic_way, exp_way);
    chk({tag, "_age"}, vic_age, exp_age);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, vic_v, 1);
      chk({tag, "_hold_way"}, vic_way, exp_way);
      chk({tag, "_hold_age"}, vic_age, exp_age);
    end
    @(negedge clk);
    rdy_in = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b0;
    chk({tag, "_done_valid_low"}, vic_v, 0);
    chk({tag, "_idle_ready"}, req_rdy, 1);
  endtask

  typedef struct {
    logic        av;
    int          aw;
    logic        iv;
    int          iw;
    logic [15:0] cond;
    int          cw;
    int          cage;
  } vec_t;

  vec_t vecs[15];
  int   seq[$];

  initial begin
    vecs[0]  = '{1'b1, 0, 1'b0, 0, 16'h0001, 0, 0};
    vecs[1]  = '{1'b1, 1, 1'b0, 0, 16'h0003, 0, 1};
    vecs[2]  = '{1'b1, 2, 1'b0, 0, 16'h0007, 0, 2};
    vecs[3]  = '{1'b0, 0, 1'b0, 0, 16'h0007, 1, 1};
    vecs[4]  = '{1'b0, 0, 1'b0, 0, 16'h0007, 2, 0};
    vecs[5]  = '{1'b0, 0, 1'b1, 0, 16'h0006, 0, 0};
    vecs[6]  = '{1'b0, 0, 1'b1, 1, 16'h0004, 2, 0};
    vecs[7]  = '{1'b0, 0, 1'b1, 2, 16'h0000, 2, 0};
    vecs[8]  = '{1'b1, 4, 1'b1, 4, 16'h0000, 4, 0};
    vecs[9]  = '{1'b1, 6, 1'b0, 0, 16'h0040, 6, 0};
    vecs[10] = '{1'b1, 4, 1'b0, 0, 16'h0050, 6, 1};
    vecs[11] = '{1'b1, 6, 1'b1, 4, 16'h0040, 6, 0};
    vecs[12] = '{1'b0, 0, 1'b0, 0, 16'h0040, 4, 0};
    vecs[13] = '{1'b1, 7, 1'b1, 7, 16'h0040, 6, 1};
    vecs[14] = '{1'b0, 0, 1'b0, 0, 16'h0040, 7, 0};

    rst_n = 1'b0;
    acc_v = 1'b0; acc_w = '0;
    inv_v = 1'b0; inv_w = '0;
    req_v = 1'b0; rdy_in = 1'b0;
    #12;
    chk("rst_cond", cond, 0);
    chk("rst_flat_lo", int'(flat[31:0]), 0);
    chk("rst_flat_hi", int'(flat[63:32]), 0);
    chk("rst_ready", req_rdy, 1);
    chk("rst_vvalid", vic_v, 0);
    chk("rst_vway", vic_way, 0);
    chk("rst_vage", vic_age, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].av, vecs[i].aw, vecs[i].iv, vecs[i].iw);
      chk($sformatf("vec%0d_cond", i), cond, vecs[i].cond);
      chk($sformatf("vec%0d_age", i), age_of(vecs[i].cw), vecs[i].cage);
    end

    // saturation: way 3 then way 5 hammered
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 3, 1'b0, 0);
    chk("sat_cond3", cond, 16'h0008);
    chk("sat_w3_0", age_of(3), 0);
    step(1'b1, 5, 1'b0, 0);
    chk("sat_cond35", cond, 16'h0028);
    chk("sat_w3_1", age_of(3), 1);
    chk("sat_w5_0", age_of(5), 0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 5, 1'b0, 0);
      chk($sformatf("sat_w3_i%0d", i), age_of(3), (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("sat_w5_i%0d", i), age_of(5), 0);
    end
    chk("sat_cond_end", cond, 16'h0028);

    // all ways valid, ways 2 and 9 saturated: tie resolves to way 2
    do_reset();
    seq = '{2, 9, 0, 1, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14, 15, 15};
    foreach (seq[i]) step(1'b1, seq[i], 1'b0, 0);
    chk("v1_cond", cond, 16'hffff);
    chk("v1_w2", age_of(2), 15);
    chk("v1_w9", age_of(9), 15);
    chk("v1_w0", age_of(0), 14);
    run_victim("v1", 16, 2, 15, 2);
    chk("v1_live_inv2", cond, 16'hfffb);

    // all valid except way 7
    do_reset();
    seq = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15};
    foreach (seq[i]) step(1'b1, seq[i], 1'b0, 0);
    chk("v2_cond", cond, 16'hff7f);
`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
    run_victim("v2", 8, 7, 0, -1);
`else
    run_victim("v2", 16, 0, 14, -1);
`endif

    // all ways invalid
    do_reset();
`ifdef WAY_AGE_TRACKER_INVALID_FIRST_EN
    run_victim("v3", 1, 0, 0, -1);
`else
    run_victim("v3", 16, 0, 0, -1);
`endif

    // reset while scanning index 5
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0, 0);
    @(negedge clk);
    req_v = 1'b1;
    @(posedge clk);
    #1;
    req_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", req_rdy, 0);
    rst_n = 1'b0;
    #2;
    chk("mid_ready", req_rdy, 1);
    chk("mid_vvalid", vic_v, 0);
    chk("mid_cond", cond, 0);
    chk("mid_flat_lo", int'(flat[31:0]), 0);
    chk("mid_flat_hi", int'(flat[63:32]), 0);
    chk("mid_vway", vic_way, 0);
    chk("mid_vage", vic_age, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_after_ready", req_rdy, 1);
    chk("mid_after_vvalid", vic_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
